special_case_resolver: RTL and testbench
========================================

// Module: special_case_resolver
// PURPOSE
//  Pipelined stage directly downstream of the special-case detector in the HUB multiplier.
//  Takes operands X, Y and their 3-bit special-case codes; decides whether the product is fixed by a special case.
//  If so, builds the final HUB result so the mantissa/exponent datapath is bypassed; otherwise forwards X, Y unchanged.
//  Valid/ready handshake on both sides; 2-stage pipeline with full backpressure support.
// PARAMETERS
//  M             23  mantissa width
//  E             8   exponent width
//  special_case  7   number of special-case codes; code width CW = $clog2(special_case)
// PORTS
//  clk            in   1       clock, all logic on rising edge
//  rst            in   1       synchronous, active-high reset
//  in_valid       in   1       input beat valid
//  in_ready       out  1       stage can accept a beat this cycle
//  in_x           in   E+M+1   operand X
//  in_y           in   E+M+1   operand Y
//  in_x_code      in   CW      X code: 0 none, 1 +inf, 2 -inf, 3 +0, 4 -0, 5 +1, 6 -1
//  in_y_code      in   CW      Y code, same encoding
//  out_valid      out  1       output beat valid
//  out_ready      in   1       consumer accepts beat
//  out_special    out  1       1: out_result is final; 0: product must be computed by datapath
//  out_result     out  E+M+1   final product when out_special=1, else all zeros
//  out_x, out_y   out  E+M+1   operands forwarded unchanged (all beats)
//  out_invalid    out  1       inf*0 beat
//  flags_clr      in   1       clear sticky flag (only with SCR_STICKY_FLAGS_EN)
//  sticky_invalid out  1       sticky OR of accepted out_invalid beats (only with SCR_STICKY_FLAGS_EN)
// BEHAVIOUR
//  - Reset: out_valid=0, out_special=0, out_invalid=0, out_result/out_x/out_y=0, sticky_invalid=0; all in-flight beats dropped.
//  - Stage 1 registers operands, codes and s = X[E+M]^Y[E+M]; stage 2 registers resolved result.
//  - Latency: beat accepted at cycle t (in_valid&&in_ready) appears with out_valid=1 at cycle t+2 if not stalled.
//  - Each stage loads when empty or its content moves on the same cycle; in_ready = !s1_valid || s1 moves.
//  - out_ready=0 with out_valid=1: all out_* held stable; at most 2 beats buffered; no loss, no duplication, order kept.
//  - Simultaneous output drain and input accept in a full pipeline: throughput 1 beat/cycle.
//  - Code 7 (unused) treated as 0 (none).
//  - Resolution priority (first match wins), INF=s,{E+M{1}}, ZERO=s,{E+M{0}}:
//    1. one inf, other zero -> out_special=1, out_result=+inf {0,{E+M{1}}}, out_invalid=1
//    2. either inf          -> INF with sign s
//    3. either zero         -> ZERO with sign s
//    4. both +/-1           -> {s,1'b1,{E+M-1{0}}}
//    5. X is +/-1           -> {s, Y[E+M-1:0]};  Y is +/-1 -> {s, X[E+M-1:0]}
//    6. otherwise           -> out_special=0, out_result=0, out_invalid=0
//  - out_invalid=1 only in case 1.
//  - Reset asserted mid-stall: next cycle out_valid=0; in_ready=1 the cycle after reset deasserts.
// CONFIGURATION
//  - SCR_STICKY_FLAGS_EN defined: sticky_invalid sets on the cycle after an out_valid&&out_ready&&out_invalid beat.
//    Cleared by flags_clr (one cycle later) or rst; set wins over clear when both occur in the same cycle.
//  - SCR_STICKY_FLAGS_EN undefined: flags_clr ignored, sticky_invalid tied to 0, no sticky register.
// TESTING (M=23, E=8)
//  - X=0x7FFFFFFF code1, Y=0xC0000000 code6, out_ready=1 -> 2 cycles later: out_special=1, out_result=0xFFFFFFFF, out_invalid=0.
//  - X=0x7FFFFFFF code1, Y=0x00000000 code3 -> out_result=0x7FFFFFFF, out_invalid=1; with SCR_STICKY_FLAGS_EN sticky_invalid=1 until flags_clr.
//  - X=0xC0000000 code6, Y=0x3F800000 code0 -> out_special=1, out_result=0xBF800000.
//  - X=0x3F800000, Y=0x40400000, codes 0 -> out_special=0, out_result=0, out_x=0x3F800000, out_y=0x40400000.
//  - out_ready=0, 3 back-to-back beats -> in_ready low after 2 accepted; release -> 3 beats out in order, 1/cycle.
//  - rst pulsed while 2 beats stalled -> out_valid=0 next cycle, no stale beat emitted after reset.

Source files
------------

// File: rtl/special_case_resolver.sv
// rtl/special_case_resolver.sv - special-case resolution stage for the HUB multiplier
//
// Sits after the special-case detector. Works out whether a product is fixed
// by its operand codes (inf, zero, +/-1). If so it builds the final HUB result
// so the mantissa/exponent datapath can be bypassed. Operands are always passed
// through unchanged. Two register stages, valid/ready on both sides, with full
// backpressure.
//
// Ports:
//   clk, rst                   clock; synchronous active-high reset
//   in_valid/in_ready          input handshake
//   in_x, in_y                 operands, width E+M+1
//   in_x_code, in_y_code       codes: 0 none, 1 +inf, 2 -inf, 3 +0, 4 -0, 5 +1, 6 -1 (7 = none)
//   out_valid/out_ready        output handshake
//   out_special                out_result is the final product
//   out_result                 resolved product, zero when not special
//   out_x, out_y               forwarded operands
//   out_invalid                inf * 0 beat
//   flags_clr, sticky_invalid  sticky invalid flag and its clear
//
// Optional feature macro: SCR_STICKY_FLAGS_EN (sticky invalid flag register)

module special_case_resolver #(
    parameter int M            = 23,
    parameter int E            = 8,
    parameter int special_case = 7,
    localparam int W           = E + M + 1,
    localparam int CW          = $clog2(special_case)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_x,
    input  logic [W-1:0]  in_y,
    input  logic [CW-1:0] in_x_code,
    input  logic [CW-1:0] in_y_code,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_special,
    output logic [W-1:0]  out_result,
    output logic [W-1:0]  out_x,
    output logic [W-1:0]  out_y,
    output logic          out_invalid,
    input  logic          flags_clr,
    output logic          sticky_invalid
);

    localparam logic [CW-1:0] C_PINF  = CW'(1);
    localparam logic [CW-1:0] C_NINF  = CW'(2);
    localparam logic [CW-1:0] C_PZERO = CW'(3);
    localparam logic [CW-1:0] C_NZERO = CW'(4);
    localparam logic [CW-1:0] C_PONE  = CW'(5);
    localparam logic [CW-1:0] C_NONE1 = CW'(6);

    // Stage 1 registers
    logic          s1_valid;
    logic [W-1:0]  s1_x;
    logic [W-1:0]  s1_y;
    logic [CW-1:0] s1_xc;
    logic [CW-1:0] s1_yc;
    logic          s1_s;

    // Stage 2 (output register) loads when empty or its beat is taken
    logic s2_load;
    logic s1_move;
    logic s1_load;

    assign s2_load  = !out_valid || out_ready;
    assign s1_move  = s1_valid && s2_load;
    assign in_ready = !s1_valid || s1_move;
    assign s1_load  = in_valid && in_ready;

    // Resolution of the stage-1 beat. Code 7 matches none of the classes
    // below, so it behaves exactly like code 0.
    logic         x_inf, y_inf, x_zero, y_zero, x_one, y_one;
    logic         r_special;
    logic         r_invalid;
    logic [W-1:0] r_result;

    always_comb begin
        x_inf  = (s1_xc == C_PINF)  || (s1_xc == C_NINF);
        y_inf  = (s1_yc == C_PINF)  || (s1_yc == C_NINF);
        x_zero = (s1_xc == C_PZERO) || (s1_xc == C_NZERO);
        y_zero = (s1_yc == C_PZERO) || (s1_yc == C_NZERO);
        x_one  = (s1_xc == C_PONE)  || (s1_xc == C_NONE1);
        y_one  = (s1_yc == C_PONE)  || (s1_yc == C_NONE1);

        r_special = 1'b1;
        r_invalid = 1'b0;
        r_result  = '0;

        if ((x_inf && y_zero) || (x_zero && y_inf)) begin
            // inf * 0 yields a canonical positive inf, regardless of sign
            r_result  = {1'b0, {(E+M){1'b1}}};
            r_invalid = 1'b1;
        end else if (x_inf || y_inf) begin
            r_result = {s1_s, {(E+M){1'b1}}};
        end else if (x_zero || y_zero) begin
            r_result = {s1_s, {(E+M){1'b0}}};
        end else if (x_one && y_one) begin
            r_result = {s1_s, 1'b1, {(E+M-1){1'b0}}};
        end else if (x_one) begin
            r_result = {s1_s, s1_y[E+M-1:0]};
        end else if (y_one) begin
            r_result = {s1_s, s1_x[E+M-1:0]};
        end else begin
            r_special = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_xc    <= '0;
            s1_yc    <= '0;
            s1_s     <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1_x     <= in_x;
            s1_y     <= in_y;
            s1_xc    <= in_x_code;
            s1_yc    <= in_y_code;
            s1_s     <= in_x[E+M] ^ in_y[E+M];
        end else if (s1_move) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_special <= 1'b0;
            out_result  <= '0;
            out_x       <= '0;
            out_y       <= '0;
            out_invalid <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            // Data only changes with a real beat so a drained output keeps
            // its last contents instead of showing stage-1 leftovers.
            if (s1_valid) begin
                out_special <= r_special;
                out_result  <= r_result;
                out_x       <= s1_x;
                out_y       <= s1_y;
                out_invalid <= r_invalid;
            end
        end
    end

`ifdef SCR_STICKY_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_invalid <= 1'b0;
        end else if (out_valid && out_ready && out_invalid) begin
            // Set takes priority over a simultaneous clear
            sticky_invalid <= 1'b1;
        end else if (flags_clr) begin
            sticky_invalid <= 1'b0;
        end
    end
`else
    logic unused_flags_clr;
    assign unused_flags_clr = flags_clr;
    assign sticky_invalid   = 1'b0;
`endif

endmodule

// File: tb/tb_special_case_resolver.sv
// tb/tb_special_case_resolver.sv - scoreboard bench for special_case_resolver

module tb_special_case_resolver;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] res;
        logic        sp;
        logic        inv;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_x = '0;
    logic [31:0] in_y = '0;
    logic [2:0]  in_x_code = '0;
    logic [2:0]  in_y_code = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_special;
    logic [31:0] out_result;
    logic [31:0] out_x;
    logic [31:0] out_y;
    logic        out_invalid;
    logic        flags_clr = 1'b0;
    logic        sticky_invalid;

    int   errors = 0;
    int   checks = 0;
    int   pops   = 0;
    exp_t sbq[$];

    special_case_resolver #(.M(23), .E(8), .special_case(7)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y),
        .in_x_code(in_x_code), .in_y_code(in_y_code),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_special(out_special), .out_result(out_result),
        .out_x(out_x), .out_y(out_y),
        .out_invalid(out_invalid),
        .flags_clr(flags_clr), .sticky_invalid(sticky_invalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Monitor: every valid output cycle is compared against the queue head,
    // so held beats under stall are checked too; pop on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && out_valid) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got out_x=%h out_y=%h expected no beat", out_x, out_y);
                end else begin
                    e = sbq[0];
                    if (out_special !== e.sp || out_result !== e.res || out_invalid !== e.inv ||
                        out_x !== e.x || out_y !== e.y) begin
                        errors++;
                        $display("FAIL beat: got sp=%0b res=%h inv=%0b x=%h y=%h expected sp=%0b res=%h inv=%0b x=%h y=%h",
                                 out_special, out_result, out_invalid, out_x, out_y,
                                 e.sp, e.res, e.inv, e.x, e.y);
                    end
                    if (out_ready) begin
                        void'(sbq.pop_front());
                        pops++;
                    end
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic drive_beat(input logic [31:0] x, input logic [2:0] xc,
                              input logic [31:0] y, input logic [2:0] yc,
                              input logic sp, input logic [31:0] res, input logic inv);
        exp_t e;
        bit   accepted = 0;
        e.x = x; e.y = y; e.res = res; e.sp = sp; e.inv = inv;
        in_x = x; in_y = y; in_x_code = xc; in_y_code = yc;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            #1;
            if (in_ready) begin
                sbq.push_back(e);
                accepted = 1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 for 20 cycles expected acceptance x=%h", x);
        end
    endtask

    initial begin
        int p0;
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        exp_t e;
        repeat (3) @(negedge clk);
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'h0);
        check("rst_out_x", out_x, 32'h0);
        check("rst_flags", {29'd0, out_special, out_invalid, sticky_invalid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Latency: accepted before edge t, visible after edge t+2
        @(negedge clk);
        e.x = 32'h7FFFFFFF; e.y = 32'hC0000000; e.res = 32'hFFFFFFFF; e.sp = 1'b1; e.inv = 1'b0;
        in_x = e.x; in_x_code = 3'd1; in_y = e.y; in_y_code = 3'd6; in_valid = 1'b1;
        #1;
        check("lat_in_ready", 32'(in_ready), 32'd1);
        sbq.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        check("lat_t1_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        #2;
        check("lat_t2_out_valid", 32'(out_valid), 32'd1);
        @(negedge clk);

        // Back-to-back directed vectors at full throughput
        drive_beat(32'h7FFFFFFF, 3'd1, 32'h00000000, 3'd3, 1'b1, 32'h7FFFFFFF, 1'b1);
        drive_beat(32'hC0000000, 3'd6, 32'h3F800000, 3'd0, 1'b1, 32'hBF800000, 1'b0);
        drive_beat(32'h3F800000, 3'd0, 32'h40400000, 3'd0, 1'b0, 32'h00000000, 1'b0);
        drive_beat(32'h80000000, 3'd4, 32'h40400000, 3'd0, 1'b1, 32'h80000000, 1'b0);
        drive_beat(32'hBF800000, 3'd6, 32'hBF800000, 3'd6, 1'b1, 32'h40000000, 1'b0);
        drive_beat(32'h40400000, 3'd0, 32'h3F800000, 3'd5, 1'b1, 32'h40400000, 1'b0);
        drive_beat(32'h3F800000, 3'd7, 32'h40000000, 3'd7, 1'b0, 32'h00000000, 1'b0);
        drive_beat(32'hFF800000, 3'd2, 32'h80000000, 3'd4, 1'b1, 32'h7FFFFFFF, 1'b1);
        drive_beat(32'h00000000, 3'd3, 32'hBF800000, 3'd6, 1'b1, 32'h80000000, 1'b0);
        drive_beat(32'hFF800000, 3'd2, 32'h40400000, 3'd0, 1'b1, 32'hFFFFFFFF, 1'b0);
        repeat (4) @(negedge clk);
        #2;
        check("drain_queue_empty", 32'(sbq.size()), 32'd0);

`ifdef SCR_STICKY_FLAGS_EN
        check("sticky_set", 32'(sticky_invalid), 32'd1);
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        #2;
        check("sticky_cleared", 32'(sticky_invalid), 32'd0);
`else
        check("sticky_tied_low", 32'(sticky_invalid), 32'd0);
`endif

        // Backpressure: two beats buffered, third held off, then 1/cycle drain
        @(negedge clk);
        out_ready = 1'b0;
        drive_beat(32'h3F800000, 3'd0, 32'h40400000, 3'd0, 1'b0, 32'h00000000, 1'b0);
        drive_beat(32'h40000000, 3'd5, 32'h40A00000, 3'd0, 1'b1, 32'h40A00000, 1'b0);
        in_x = 32'hC0400000; in_x_code = 3'd0; in_y = 32'h3F800000; in_y_code = 3'd5;
        in_valid = 1'b1;
        repeat (2) begin
            #2;
            check("stall_in_ready_low", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        #2;
        check("stall_out_held", out_x, 32'h3F800000);
        @(negedge clk);
        p0 = pops;
        out_ready = 1'b1;
        #2;
        check("release_in_ready", 32'(in_ready), 32'd1);
        e.x = 32'hC0400000; e.y = 32'h3F800000; e.res = 32'hC0400000; e.sp = 1'b1; e.inv = 1'b0;
        sbq.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        check("release_three_pops", 32'(pops - p0), 32'd3);
        @(negedge clk);
        #2;
        check("release_drained", 32'(out_valid), 32'd0);

        // Reset while two beats are stalled
        out_ready = 1'b0;
        drive_beat(32'h3F800000, 3'd0, 32'h40400000, 3'd0, 1'b0, 32'h00000000, 1'b0);
        drive_beat(32'hC0000000, 3'd6, 32'h3F800000, 3'd0, 1'b1, 32'hBF800000, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        #2;
        check("rst_stall_out_valid", 32'(out_valid), 32'd0);
        check("rst_stall_out_x", out_x, 32'h0);
        sbq.delete();
        p0 = pops;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_stall_in_ready", 32'(in_ready), 32'd1);
        repeat (5) @(negedge clk);
        #2;
        check("rst_no_stale_beats", 32'(pops - p0), 32'd0);
        check("final_queue_empty", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
